// File: rtl/vlib_and_reduce_pipe.sv
//=============================================================================
// Module      : vlib_and_reduce_pipe
// Description : Pipelined multi-channel AND/NAND reduction with per-bit mask
//               and a valid/ready handshake. Each of CHANNELS lanes reduces
//               WIDTH bits through a balanced pairwise-AND tree. A register
//               follows every tree level, so the latency is fixed at LEVELS
//               cycles plus any stalled cycles.
//
// Ports       : nvdla_core_clk   - clock, rising edge
//               nvdla_core_rstn  - synchronous active-low reset
//               in_valid/in_ready   - input handshake
//               in_data  [CHANNELS*WIDTH] - channel c at [c*WIDTH +: WIDTH]
//               in_mask  [CHANNELS*WIDTH] - 1 forces the data bit to 1
//               in_inv              - per-beat NAND select
//               out_valid/out_ready - output handshake
//               out_data [CHANNELS] - bit c = reduction of channel c
//
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module vlib_and_reduce_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS*WIDTH-1:0]    in_mask,
  input  logic                         in_inv,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          out_data
);

  // Pipeline depth: one register per tree level, at least one stage.
  localparam int LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);

  // Number of partial products held after tree level k (ceil(WIDTH/2^(k+1)),
  // never below one element).
  function automatic int stage_w(input int k);
    int d;
    int w;
    d = 1 << (k + 1);
    w = (WIDTH + d - 1) / d;
    return (w < 1) ? 1 : w;
  endfunction

  logic                  w_stall;
  logic                  w_accept;
  logic [LEVELS-1:0]     r_vld;
  logic [LEVELS-1:0]     r_inv;
  logic [CHANNELS-1:0]   w_last;

  // The whole pipe freezes only when the last stage cannot hand off.
  assign w_stall  = r_vld[LEVELS-1] && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;

  // Valid and inv sideband shift register, gated only by stall.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_vld <= '0;
      r_inv <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      r_inv[0] <= in_inv;
      for (int k = 1; k < LEVELS; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_inv[k] <= r_inv[k-1];
      end
    end
  end

  for (genvar K = 0; K < LEVELS; K++) begin : g_stage
    localparam int NIN = (K == 0) ? WIDTH : stage_w(K - 1);
    localparam int SW  = stage_w(K);

    logic [NIN-1:0]  w_in  [CHANNELS];
    logic [2*SW-1:0] w_pad [CHANNELS];
    logic [SW-1:0]   w_red [CHANNELS];
    logic [SW-1:0]   r_pp  [CHANNELS];

    if (K == 0) begin : g_src_in
      // Masked bits become 1 so they drop out of the AND.
      always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
          w_in[c] = in_data[c*WIDTH +: WIDTH] | in_mask[c*WIDTH +: WIDTH];
        end
      end
    end else begin : g_src_pipe
      always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
          w_in[c] = g_stage[K-1].r_pp[c];
        end
      end
    end

    // Pad to an even count with ones so an unpaired element passes through.
    always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_pad[c]          = '1;
        w_pad[c][NIN-1:0] = w_in[c];
        for (int i = 0; i < SW; i++) begin
          w_red[c][i] = w_pad[c][2*i] & w_pad[c][2*i+1];
        end
      end
    end

    always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_pp[c] <= '0;
        end
      end else if (!w_stall) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_pp[c] <= w_red[c];
        end
      end
    end

    if (K == LEVELS - 1) begin : g_tap
      always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
          w_last[c] = r_pp[c][0];
        end
      end
    end
  end

  assign out_valid = r_vld[LEVELS-1];
  // Inversion is applied after the last register; reset state gives 0.
  assign out_data  = w_last ^ {CHANNELS{r_inv[LEVELS-1]}};

endmodule

`default_nettype wire

// File: tb/tb_vlib_and_reduce_pipe.sv
//=============================================================================
// Module      : tb_vlib_and_reduce_pipe
// Description : Directed self-checking bench for vlib_and_reduce_pipe.
//               Instance u_a: WIDTH=8, CHANNELS=2 (LEVELS=3).
//               Instance u_b: WIDTH=5, CHANNELS=1 (LEVELS=3).
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_vlib_and_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_in_data;
  logic [15:0] a_in_mask;
  logic        a_in_inv;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [1:0]  a_out_data;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_in_data;
  logic [4:0]  b_in_mask;
  logic        b_in_inv;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [0:0]  b_out_data;

  int n_total = 0;
  int n_pass  = 0;

  vlib_and_reduce_pipe #(.WIDTH(8), .CHANNELS(2)) u_a (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_valid        (a_in_valid),
    .in_ready        (a_in_ready),
    .in_data         (a_in_data),
    .in_mask         (a_in_mask),
    .in_inv          (a_in_inv),
    .out_valid       (a_out_valid),
    .out_ready       (a_out_ready),
    .out_data        (a_out_data)
  );

  vlib_and_reduce_pipe #(.WIDTH(5), .CHANNELS(1)) u_b (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_valid        (b_in_valid),
    .in_ready        (b_in_ready),
    .in_data         (b_in_data),
    .in_mask         (b_in_mask),
    .in_inv          (b_in_inv),
    .out_valid       (b_out_valid),
    .out_ready       (b_out_ready),
    .out_data        (b_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; result must appear exactly at cycle 3 and vanish at 4.
  task automatic beat(input string tag, input logic [15:0] d, input logic [15:0] m,
                      input logic inv, input logic [1:0] exp);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_mask  = m;
    a_in_inv   = inv;
    #1;
    check({tag, "_ready"}, a_in_ready, 1);
    cyc();
    a_in_valid = 1'b0;
    a_in_data  = '0;
    a_in_mask  = '0;
    a_in_inv   = 1'b0;
    check({tag, "_c1_valid"}, a_out_valid, 0);
    cyc();
    check({tag, "_c2_valid"}, a_out_valid, 0);
    cyc();
    check({tag, "_c3_valid"}, a_out_valid, 1);
    check({tag, "_c3_data"}, a_out_data, exp);
    cyc();
    check({tag, "_c4_valid"}, a_out_valid, 0);
  endtask

  // Backpressure beats: ch0 = 0xFF, ch1 = k, with a ch1 mask and inv per beat.
  logic [7:0]  bp_m [6] = '{8'hFF, 8'h00, 8'hFD, 8'h00, 8'hFB, 8'hF0};
  logic        bp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0]  bp_e [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};

  logic [15:0] fp_d [4] = '{16'hFFFF, 16'h00FF, 16'hFF00, 16'h0000};
  logic [1:0]  fp_e [3] = '{2'b11, 2'b01, 2'b10};

  initial begin
    int         sent;
    int         recv;
    int         acc;
    logic       stalled_prev;
    logic [1:0] held;

    rstn        = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_in_mask   = '0;
    a_in_inv    = 1'b0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_mask   = '0;
    b_in_inv    = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    cyc();
    cyc();
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_ready", b_in_ready, 1);
    rstn = 1'b1;
    cyc();

    // Reset flush: two beats in flight, then a one-cycle reset pulse
    a_in_valid = 1'b1;
    a_in_data  = 16'hFFFF;
    cyc();
    cyc();
    a_in_valid = 1'b0;
    a_in_data  = '0;
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("flush_valid", a_out_valid, 0);
      check("flush_data", a_out_data, 0);
      check("flush_ready", a_in_ready, 1);
      cyc();
    end

    // Basic reduction, masking, inversion, all-masked corner cases
    beat("basic",      16'hFFFE, 16'h0000, 1'b0, 2'b10);
    beat("mask_and",   16'h007F, 16'hFF80, 1'b0, 2'b11);
    beat("mask_nand",  16'h007F, 16'hFF80, 1'b1, 2'b00);
    beat("allmask_and",16'h0000, 16'hFFFF, 1'b0, 2'b11);
    beat("allmask_nand",16'h0000,16'hFFFF, 1'b1, 2'b00);
    beat("msb_zero",   16'h7FFF, 16'h0000, 1'b0, 2'b01);
    beat("ch0_b7",     16'hFF7F, 16'h0000, 1'b0, 2'b10);
    beat("ch1_b4",     16'hEFFF, 16'h0000, 1'b0, 2'b01);
    beat("ones_nand",  16'hFFFF, 16'h0000, 1'b1, 2'b00);
    beat("zero_nand",  16'h0000, 16'h0000, 1'b1, 2'b11);

    // Backpressure with out_ready pattern 1,0,0,1,0,0,...
    sent = 0;
    recv = 0;
    stalled_prev = 1'b0;
    held = '0;
    for (int t = 0; t < 60 && recv < 6; t++) begin
      a_out_ready = (t % 3 == 0);
      a_in_valid  = (sent < 6);
      if (sent < 6) begin
        a_in_data = {5'(sent), 3'b000, 8'hFF} >> 0;
        a_in_data = {8'(sent), 8'hFF};
        a_in_mask = {bp_m[sent], 8'h00};
        a_in_inv  = bp_i[sent];
      end else begin
        a_in_data = '0;
        a_in_mask = '0;
        a_in_inv  = 1'b0;
      end
      #1;
      check("bp_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
      if (stalled_prev) begin
        check("bp_hold_valid", a_out_valid, 1);
        check("bp_hold_data", a_out_data, held);
      end
      if (a_out_valid && a_out_ready) begin
        check("bp_data", a_out_data, bp_e[recv]);
        recv++;
      end
      stalled_prev = a_out_valid && !a_out_ready;
      held = a_out_data;
      if (a_in_valid && a_in_ready) sent++;
      cyc();
    end
    check("bp_recv_count", recv, 6);
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_in_mask   = '0;
    a_in_inv    = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_no_extra", a_out_valid, 0);
      cyc();
    end

    // Full pipeline: out_ready held low, beats offered continuously
    a_out_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      a_in_valid = 1'b1;
      a_in_data  = fp_d[(acc < 3) ? acc : 3];
      #1;
      if (a_in_valid && a_in_ready) acc++;
      cyc();
    end
    check("full_accepted", acc, 3);
    check("full_ready", a_in_ready, 0);
    check("full_valid", a_out_valid, 1);
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("drain_valid", a_out_valid, 1);
      check("drain_data", a_out_data, fp_e[j]);
      cyc();
    end
    #1;
    check("drain_done", a_out_valid, 0);

    // Odd width: all 32 values streamed back-to-back, latency 3
    for (int t = 0; t < 36; t++) begin
      b_in_valid = (t < 32);
      b_in_data  = 5'(t);
      #1;
      if (t >= 3 && t < 35) begin
        check("odd_valid", b_out_valid, 1);
        check("odd_data", b_out_data, ((t - 3) == 31) ? 1 : 0);
      end else begin
        check("odd_idle", b_out_valid, 0);
      end
      cyc();
    end
    b_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vlib_and_reduce_pipe.md
# vlib_and_reduce_pipe

Parametrised, pipelined multi-channel AND-reduction cell for the vlibs library. It generalises the two-input AND primitive to CHANNELS independent reductions of WIDTH bits each, with per-bit masking, an optional inverted (NAND) result and a valid/ready handshake. It is used where wide match, all-done or all-granted terms in datapath control would otherwise form a long combinational AND chain that misses timing.

## Interface
Parameters:
- WIDTH, 8: input bits reduced per channel; legal range 1..64.
- CHANNELS, 4: number of independent reductions; legal range 1..32.
- LEVELS, derived as max(1, ceil(log2(WIDTH))): pipeline depth in cycles. Not overridable.

Ports:
- nvdla_core_clk  input  1  sole clock; all state updates on the rising edge.
- nvdla_core_rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_mask  input  CHANNELS*WIDTH  same layout; a bit at 1 excludes the matching data bit, which is treated as 1.
- in_inv  input  1  per-beat mode: 0 gives AND, 1 gives NAND on every channel of the beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  CHANNELS  bit c is the reduction result of channel c.

## Operation
- The beat is accepted when in_valid && in_ready.
- Pre-processing happens before the first register: effective bit = in_data | in_mask.
- Tree structure: at each level, adjacent pairs are ANDed. An element with no pair passes through unchanged, so it behaves as if ANDed with 1.
- A register follows every tree level. There are exactly LEVELS register stages.
- WIDTH=1 gives one register stage and the result equals the effective bit.
- in_inv is carried down the pipeline as a 1-bit sideband alongside each beat. It is applied as an XOR at the final stage output.
- If all bits of a channel are masked, the result is 1 for AND and 0 for NAND.
- Each stage holds a valid bit, the partial products and the inv sideband.
- Stall rule: stall = out_valid && !out_ready.
  - On stall, every stage holds its contents.
  - Otherwise every stage shifts forward. Stage 0 loads the accepted beat, or loads a bubble (valid=0) when no beat is accepted.
- in_ready = !stall. It is combinational from out_valid (a register) and out_ready. There is no combinational path from in_valid to in_ready.
- Bubbles are not compressed. The pipeline is a fixed-latency shift register gated only by stall.
- Channels are fully independent. There is no cross-channel logic.
- No state machine exists beyond the per-stage valid bits. No counters exist.
- out_data and out_valid are driven directly from the last stage register.

## Timing
- Reset, when nvdla_core_rstn=0 at a rising edge:
  - all stage valid bits are cleared to 0;
  - all partial-product and inv registers are cleared to 0;
  - out_valid=0 and out_data=0 from the next cycle.
- in_ready=1 during and immediately after reset, because out_valid=0.
- Reset asserted mid-operation discards all in-flight beats. None are delivered afterwards.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+LEVELS-1, provided no stall occurs in between. That is, it is visible LEVELS cycles after the cycle in which it was accepted.
- Each stalled cycle adds exactly one cycle of latency to every in-flight beat.
- Throughput is one beat per cycle while out_ready=1.
- If out_valid && out_ready && in_valid occur in the same cycle, the output is consumed, the pipeline shifts, and the new beat is accepted. Nothing is lost or duplicated.
- While stalled, in_valid is ignored; the upstream must hold its beat.
- out_data is stable whenever out_valid=1 and out_ready=0.
- Capacity is LEVELS beats in flight. Full means every stage is valid and stalled; in that state in_ready=0.

## Test plan
Unless stated otherwise, use WIDTH=8, CHANNELS=2, LEVELS=3 and out_ready held at 1.
- Reset flush: load 2 beats, then pulse nvdla_core_rstn low for 1 cycle. Required: out_valid stays 0 for 10 cycles, out_data=0, in_ready=1.
- Basic reduction: in_data=0xFF_FE, mask=0, inv=0, accepted at cycle 0. Required: out_valid=1 at cycle 3 with out_data=2'b10; out_valid=0 in cycle 4.
- Masking and inversion:
  - data=0x00_7F, mask=0xFF_80, inv=0 gives out_data=2'b11.
  - The same beat with inv=1 gives 2'b00.
- Backpressure: stream 6 back-to-back beats (ch0 = 0xFF, ch1 = k for k=0..5) while out_ready toggles 1,0,0,1,...
  - Required: outputs arrive in order with no loss or duplication.
  - out_data is stable during stalls.
  - in_ready equals !(out_valid && !out_ready) in every cycle.
- Full pipeline: hold out_ready=0 and offer beats continuously. Required: exactly 3 beats are accepted, in_ready then stays 0, and releasing out_ready drains 3 beats in 3 consecutive cycles.
- Odd width: WIDTH=5, CHANNELS=1, LEVELS=3. Run all 32 input values with mask=0. Required: result is 1 only for 0x1F, and latency is 3 cycles.
